// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
//
// Purpose:
//   Brings the asynchronous level input `cin` into the `clk` domain through a
//   flop chain. It then detects rising and/or falling transitions of the
//   synchronized level. Each selected transition produces a pulse on `cout`
//   that lasts PULSE_LEN cycles. A new event during a pulse restarts the
//   pulse length, so closely spaced events merge into one longer pulse.
//
// Optional feature:
//   `define EDGE_DEBOUNCE_EN  inserts a debounce filter between the
//   synchronizer and the edge detector. The filtered level only follows the
//   synchronized level after it has been stable for DEBOUNCE_CYCLES cycles.
//
// Parameters:
//   SYNC_STAGES      2..4    synchronizer depth
//   EDGE_TYPE        0/1/2   0 = rising, 1 = falling, 2 = both edges
//   PULSE_LEN        1..255  cout high time per event, in clk cycles
//   DEBOUNCE_CYCLES  2..255  stable count (used only with EDGE_DEBOUNCE_EN)
//
// Ports:
//   clk   in   system clock, rising-edge active
//   rstn  in   asynchronous active-low reset
//   cin   in   asynchronous level input
//   cout  out  edge pulse, decoded from the pulse counter register
// -----------------------------------------------------------------------------
module edge_det #(
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int PULSE_LEN       = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic cin,
    output logic cout
);

    // Out-of-range parameters stop elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_badSyncStages
        $error("edge_det: SYNC_STAGES must be in 2..4");
    end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_badEdgeType
        $error("edge_det: EDGE_TYPE must be 0, 1 or 2");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_badPulseLen
        $error("edge_det: PULSE_LEN must be in 1..255");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_badDebounce
        $error("edge_det: DEBOUNCE_CYCLES must be in 2..255");
    end

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_level;
    logic                   r_prev;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_event;
    logic [7:0]             r_cnt;

    // Synchronizer chain. cin enters at bit 0, and the oldest sample is at
    // the top. Reset clears the chain, so a high cin during reset is reported
    // as a fresh rising edge once the chain refills.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cin};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_filt;
    logic [7:0] r_dbCnt;

    // Debounce filter. The counter runs only while the synchronized level
    // disagrees with the filtered level, and any agreement resets it. The
    // filtered level flips on the cycle that completes DEBOUNCE_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_filt  <= 1'b0;
            r_dbCnt <= '0;
        end else if (w_s == r_filt) begin
            r_dbCnt <= '0;
        end else if (r_dbCnt == DB_LAST) begin
            r_filt  <= w_s;
            r_dbCnt <= '0;
        end else begin
            r_dbCnt <= r_dbCnt + 8'd1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_s;
`endif

    // Previous-level register for the edge detector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_rise = w_level & ~r_prev;
    assign w_fall = ~w_level & r_prev;

    // Edge selection is static, so this collapses to a single gate in the
    // netlist.
    always_comb begin
        w_event = 1'b0;
        if (EDGE_TYPE == 0) begin
            w_event = w_rise;
        end else if (EDGE_TYPE == 1) begin
            w_event = w_fall;
        end else begin
            w_event = w_rise | w_fall;
        end
    end

    // Pulse counter. An event always reloads the counter to the full length.
    // This covers a retrigger in the middle of a pulse, which then extends
    // instead of being dropped. With no event, the counter drains to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_event) begin
            r_cnt <= PULSE_LOAD;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign cout = (r_cnt != 8'd0);

endmodule

// File: tb/tb_edge_det.sv
// -----------------------------------------------------------------------------
// tb_edge_det
//
// Purpose:
//   Drives four edge_det instances with different parameter sets from one
//   shared cin stimulus. A window-based reference model checks their outputs.
//   The model keeps the list of cin values sampled at each clock edge since
//   reset release. An event exists at edge m when the samples taken S and S+1
//   edges earlier differ in the selected direction. cout must be high after
//   edge n when some event lies in the last PULSE_LEN edges up to n.
//
// Instances:
//   u0  S=2 E=0 L=1  (defaults)
//   u1  S=3 E=2 L=1
//   u2  S=2 E=2 L=5
//   u3  S=4 E=1 L=3
// -----------------------------------------------------------------------------
module tb_edge_det;

    localparam int HMAX = 16384;

    logic clk = 1'b0;
    logic rstn;
    logic cin;
    logic cout0, cout1, cout2, cout3;

    int   nVectors     = 0;
    int   nMiscompares = 0;
    int   nEdge        = 0;
    logic hist [0:HMAX-1];

    edge_det #(.SYNC_STAGES(2), .EDGE_TYPE(0), .PULSE_LEN(1)) u0 (
        .clk(clk), .rstn(rstn), .cin(cin), .cout(cout0));
    edge_det #(.SYNC_STAGES(3), .EDGE_TYPE(2), .PULSE_LEN(1)) u1 (
        .clk(clk), .rstn(rstn), .cin(cin), .cout(cout1));
    edge_det #(.SYNC_STAGES(2), .EDGE_TYPE(2), .PULSE_LEN(5)) u2 (
        .clk(clk), .rstn(rstn), .cin(cin), .cout(cout2));
    edge_det #(.SYNC_STAGES(4), .EDGE_TYPE(1), .PULSE_LEN(3)) u3 (
        .clk(clk), .rstn(rstn), .cin(cin), .cout(cout3));

    always #5 clk = ~clk;

    // Records the cin value seen at every rising edge since the last reset.
    always @(posedge clk) begin
        if (!rstn) begin
            nEdge = 0;
        end else begin
            nEdge = nEdge + 1;
            if (nEdge < HMAX) hist[nEdge] = cin;
        end
    end

    function automatic logic smp(input int k);
        if (k >= 1 && k <= nEdge && k < HMAX) return hist[k];
        return 1'b0;
    endfunction

    // Expected cout after edge nEdge for a given parameter set.
    function automatic logic modelCout(input int s, input int e, input int l);
        logic a, b, ev;
        for (int m = nEdge - l + 1; m <= nEdge; m++) begin
            if (m >= 1) begin
                a  = smp(m - s);
                b  = smp(m - s - 1);
                ev = (e == 0) ? (a & ~b) : (e == 1) ? (~a & b) : (a ^ b);
                if (ev) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input int cycles);
        cin = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Compare process: every falling edge, all instances against the model.
    always @(negedge clk) begin
        checkOutput("u0_model", cout0, rstn ? modelCout(2, 0, 1) : 1'b0);
        checkOutput("u1_model", cout1, rstn ? modelCout(3, 2, 1) : 1'b0);
        checkOutput("u2_model", cout2, rstn ? modelCout(2, 2, 5) : 1'b0);
        checkOutput("u3_model", cout3, rstn ? modelCout(4, 1, 3) : 1'b0);
    end

    logic [3:0] patRise;
    logic [5:0] patDrop0, patDrop1, patDrop2, patDrop3;

    initial begin
        rstn = 1'b0;
        cin  = 1'b0;
        repeat (3) @(negedge clk);
        #1 checkOutput("reset_u0", cout0, 1'b0);
        checkOutput("reset_u2", cout2, 1'b0);
        rstn = 1'b1;
        applyStimulus(1'b0, 3);

        // Rising edge with defaults: high only between the 3rd and 4th edge
        // counting E0 as the first.
        $display("[TB] rising edge latency");
        patRise = 4'b0100;
        cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rise_u0", cout0, patRise[i]);
            checkOutput("rise_model", modelCout(2, 0, 1), patRise[i]);
            checkOutput("rise_u3_none", cout3, 1'b0);
        end
        applyStimulus(1'b1, 46);

        // One-sample low glitch, sampled low at edge k only.
        $display("[TB] single-sample drop");
        patDrop0 = 6'b001000;
        patDrop1 = 6'b011000;
        patDrop2 = 6'b111100;
        patDrop3 = 6'b110000;
        cin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) cin = 1'b1;
            checkOutput("drop_u0", cout0, patDrop0[i]);
            checkOutput("drop_u1", cout1, patDrop1[i]);
            checkOutput("drop_u2", cout2, patDrop2[i]);
            checkOutput("drop_u3", cout3, patDrop3[i]);
            checkOutput("drop_model", modelCout(3, 2, 1), patDrop1[i]);
        end
        applyStimulus(1'b1, 10);

        // cin high through reset, then reset reasserted mid-pulse.
        $display("[TB] reset release with cin high");
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rel_u0_high", cout0, 1'b1);
        checkOutput("rel_u2_high", cout2, 1'b1);
        checkOutput("rel_u1_low", cout1, 1'b0);
        #1 rstn = 1'b0;
        #1;
        checkOutput("async_rst_u0", cout0, 1'b0);
        checkOutput("async_rst_u2", cout2, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Randomized phase with a mid-cycle reset after every block.
        $display("[TB] random stimulus");
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 200; c++) begin
                applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
            end
            @(posedge clk);
            #2 rstn = 1'b0;
            #1;
            checkOutput("rand_rst_u2", cout2, 1'b0);
            checkOutput("rand_rst_u3", cout3, 1'b0);
            cin = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            rstn = 1'b1;
        end
        applyStimulus(1'b0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
